// File: rtl/link_sync_ctrl_pkg.sv
// Shared link-sync definitions: state encoding, default comma character, counter sizing.
// No logic and no latency; used by the sync controller and the serdes blocks.
// No backpressure: constants and types only.
package link_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_SLIP    = 2'd1,
        ST_LOCKING = 2'd2,
        ST_ACTIVE  = 2'd3
    } state_t;

    localparam logic [7:0] LINK_COMMA = 8'hBC;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/link_sync_ctrl_if.sv
// Word-stream bundle between deserializer-side logic and link_sync_ctrl.
// Stats signals exist only when LINK_SYNC_STATS_EN is defined.
// No flow control: one word per clk_f, no backpressure.
interface link_sync_ctrl_if;

    logic       link_en;
    logic [7:0] word_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;
    logic       bitslip;
    logic       sync_lost;
    logic [1:0] state_out;
`ifdef LINK_SYNC_STATS_EN
    logic       stats_clr;
    logic [7:0] slip_cnt;
    logic [7:0] loss_cnt;

    modport slave (
        input  link_en, word_in, stats_clr,
        output data_out, valid_out, active_out, bitslip, sync_lost, state_out,
        output slip_cnt, loss_cnt
    );
    modport master (
        output link_en, word_in, stats_clr,
        input  data_out, valid_out, active_out, bitslip, sync_lost, state_out,
        input  slip_cnt, loss_cnt
    );
`else
    modport slave (
        input  link_en, word_in,
        output data_out, valid_out, active_out, bitslip, sync_lost, state_out
    );
    modport master (
        output link_en, word_in,
        input  data_out, valid_out, active_out, bitslip, sync_lost, state_out
    );
`endif

endinterface

// File: rtl/link_sync_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count updates one clock after inc/clr.
// No backpressure: increments beyond MAX are absorbed.
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign at_max = (count == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/link_sync_ctrl.sv
// Comma-based link sync: hunts for COMMA runs, bitslips when misaligned, forwards payload when ACTIVE.
// Latency: word_in -> data_out/valid_out is 1 clk_f; optional LINK_SYNC_STATS_EN adds slip/loss counters.
// No backpressure: every word is consumed each cycle; payload is dropped outside ACTIVE.
module link_sync_ctrl
    import link_pkg::*;
#(
    parameter logic [7:0] COMMA     = LINK_COMMA,
    parameter int         LOCK_CNT  = 4,
    parameter int         SEARCH_TO = 16,
    parameter int         SLIP_WAIT = 2,
    parameter int         GAP_MAX   = 64
) (
    input  logic             clk_f,
    input  logic             reset_L,
    link_sync_ctrl_if.slave  lnk
);

    localparam int SW = cnt_width(SEARCH_TO);
    localparam int WW = cnt_width(SLIP_WAIT);
    localparam int LW = cnt_width(LOCK_CNT);
    localparam int GW = cnt_width(GAP_MAX);

    // Terminal values are one below the target: the word being evaluated is what reaches it.
    localparam logic [SW-1:0] SEARCH_M1 = SW'(SEARCH_TO - 1);
    localparam logic [WW-1:0] WAIT_M1   = WW'(SLIP_WAIT - 1);
    localparam logic [LW-1:0] LOCK_M1   = LW'(LOCK_CNT - 1);
    localparam logic [GW-1:0] GAP_M1    = GW'(GAP_MAX - 1);

    state_t     state, state_nxt;
    logic [7:0] data_q, data_nxt;
    logic       valid_q, valid_nxt;
    logic       active_q, active_nxt;
    logic       bitslip_q, bitslip_nxt;
    logic       lost_q, lost_nxt;

    logic [SW-1:0] search_cnt;
    logic [WW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic [GW-1:0] gap_cnt;
    logic search_at_max, wait_at_max, lock_at_max, gap_at_max;
    logic search_inc, search_clr, wait_inc, wait_clr;
    logic lock_inc, lock_clr, gap_inc, gap_clr;

    logic is_comma, search_hit, wait_done, lock_done, gap_hit;

    assign is_comma   = (lnk.word_in == COMMA);
    assign search_hit = (search_cnt == SEARCH_M1) || search_at_max;
    assign wait_done  = (wait_cnt == WAIT_M1) || wait_at_max;
    assign lock_done  = (lock_cnt == LOCK_M1) || lock_at_max;
    assign gap_hit    = (gap_cnt == GAP_M1) || gap_at_max;

    sat_counter #(.WIDTH(SW), .MAX(SEARCH_TO)) u_search_cnt (
        .clk(clk_f), .rst_n(reset_L), .clr(search_clr), .inc(search_inc),
        .count(search_cnt), .at_max(search_at_max)
    );
    sat_counter #(.WIDTH(WW), .MAX(SLIP_WAIT)) u_wait_cnt (
        .clk(clk_f), .rst_n(reset_L), .clr(wait_clr), .inc(wait_inc),
        .count(wait_cnt), .at_max(wait_at_max)
    );
    sat_counter #(.WIDTH(LW), .MAX(LOCK_CNT)) u_lock_cnt (
        .clk(clk_f), .rst_n(reset_L), .clr(lock_clr), .inc(lock_inc),
        .count(lock_cnt), .at_max(lock_at_max)
    );
    sat_counter #(.WIDTH(GW), .MAX(GAP_MAX)) u_gap_cnt (
        .clk(clk_f), .rst_n(reset_L), .clr(gap_clr), .inc(gap_inc),
        .count(gap_cnt), .at_max(gap_at_max)
    );

    // Counters clear by default; each state only releases the counter it owns.
    always_comb begin
        state_nxt   = state;
        data_nxt    = data_q;
        valid_nxt   = 1'b0;
        active_nxt  = 1'b0;
        bitslip_nxt = 1'b0;
        lost_nxt    = 1'b0;
        search_inc  = 1'b0;
        search_clr  = 1'b1;
        wait_inc    = 1'b0;
        wait_clr    = 1'b1;
        lock_inc    = 1'b0;
        lock_clr    = 1'b1;
        gap_inc     = 1'b0;
        gap_clr     = 1'b1;

        if (!lnk.link_en) begin
            state_nxt = ST_SEARCH;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (is_comma) begin
                        lock_clr = 1'b0;
                        lock_inc = 1'b1;
                        if (LOCK_CNT == 1) begin
                            state_nxt  = ST_ACTIVE;
                            active_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_LOCKING;
                        end
                    end else if (search_hit) begin
                        state_nxt   = ST_SLIP;
                        bitslip_nxt = 1'b1;
                    end else begin
                        search_clr = 1'b0;
                        search_inc = 1'b1;
                    end
                end
                ST_SLIP: begin
                    if (wait_done) begin
                        state_nxt = ST_SEARCH;
                    end else begin
                        wait_clr = 1'b0;
                        wait_inc = 1'b1;
                    end
                end
                ST_LOCKING: begin
                    if (!is_comma) begin
                        state_nxt = ST_SEARCH;
                    end else if (lock_done) begin
                        state_nxt  = ST_ACTIVE;
                        active_nxt = 1'b1;
                    end else begin
                        lock_clr = 1'b0;
                        lock_inc = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    active_nxt = 1'b1;
                    if (!is_comma) begin
                        if (gap_hit) begin
                            state_nxt  = ST_SEARCH;
                            active_nxt = 1'b0;
                            lost_nxt   = 1'b1;
                        end else begin
                            gap_clr   = 1'b0;
                            gap_inc   = 1'b1;
                            valid_nxt = 1'b1;
                            data_nxt  = lnk.word_in;
                        end
                    end
                end
                default: state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ST_SEARCH;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            bitslip_q <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            data_q    <= data_nxt;
            valid_q   <= valid_nxt;
            active_q  <= active_nxt;
            bitslip_q <= bitslip_nxt;
            lost_q    <= lost_nxt;
        end
    end

    assign lnk.data_out   = data_q;
    assign lnk.valid_out  = valid_q;
    assign lnk.active_out = active_q;
    assign lnk.bitslip    = bitslip_q;
    assign lnk.sync_lost  = lost_q;
    assign lnk.state_out  = state;

`ifdef LINK_SYNC_STATS_EN
    logic slip_at_max, loss_at_max;

    // Counting on the next-state pulse keeps each counter aligned with its output pulse.
    sat_counter #(.WIDTH(8), .MAX(255)) u_slip_cnt (
        .clk(clk_f), .rst_n(reset_L), .clr(lnk.stats_clr),
        .inc(bitslip_nxt && !slip_at_max),
        .count(lnk.slip_cnt), .at_max(slip_at_max)
    );
    sat_counter #(.WIDTH(8), .MAX(255)) u_loss_cnt (
        .clk(clk_f), .rst_n(reset_L), .clr(lnk.stats_clr),
        .inc(lost_nxt && !loss_at_max),
        .count(lnk.loss_cnt), .at_max(loss_at_max)
    );
`endif

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Directed bench for link_sync_ctrl: lock, slip, abort, gap loss, link_en, async reset, optional stats.
module tb_link_sync_ctrl;

    logic clk_f;
    logic reset_L;
    int   n_chk  = 0;
    int   n_fail = 0;

    link_sync_ctrl_if lnk();

    link_sync_ctrl dut (
        .clk_f   (clk_f),
        .reset_L (reset_L),
        .lnk     (lnk)
    );

    initial begin
        clk_f = 1'b0;
        forever #5 clk_f = ~clk_f;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input logic [7:0] w);
        @(negedge clk_f);
        lnk.word_in = w;
        @(posedge clk_f);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (lnk.state_out !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", lnk.state_out); end
        n_chk++; if (lnk.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", lnk.data_out); end
        n_chk++; if ({lnk.valid_out, lnk.active_out, lnk.bitslip, lnk.sync_lost} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {lnk.valid_out, lnk.active_out, lnk.bitslip, lnk.sync_lost}); end
        @(negedge clk_f);
        reset_L = 1'b1;
    endtask

    task automatic test_lock();
        int slips = 0;
        for (int i = 0; i < 4; i++) begin
            send(8'hBC);
            slips += int'(lnk.bitslip);
            n_chk++; if (lnk.active_out !== (i == 3)) begin n_fail++; $display("FAIL lock_active[%0d]: got %b want %b", i, lnk.active_out, (i == 3)); end
            n_chk++; if (lnk.state_out !== ((i == 3) ? 2'd3 : 2'd2)) begin n_fail++; $display("FAIL lock_state[%0d]: got %0d want %0d", i, lnk.state_out, (i == 3) ? 3 : 2); end
        end
        send(8'h11);
        n_chk++; if ({lnk.valid_out, lnk.data_out} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL lock_data11: got v=%b d=%h want v=1 d=11", lnk.valid_out, lnk.data_out); end
        send(8'h22);
        n_chk++; if ({lnk.valid_out, lnk.data_out} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL lock_data22: got v=%b d=%h want v=1 d=22", lnk.valid_out, lnk.data_out); end
        send(8'hBC);
        slips += int'(lnk.bitslip);
        n_chk++; if ({lnk.valid_out, lnk.data_out} !== {1'b0, 8'h22}) begin n_fail++; $display("FAIL lock_comma_hold: got v=%b d=%h want v=0 d=22", lnk.valid_out, lnk.data_out); end
        n_chk++; if (slips !== 0) begin n_fail++; $display("FAIL lock_no_slip: got %0d pulses want 0", slips); end
    endtask

    task automatic test_link_en();
        @(negedge clk_f);
        lnk.link_en = 1'b0;
        lnk.word_in = 8'h11;
        @(posedge clk_f);
        #1;
        lnk.link_en = 1'b1;
        n_chk++; if (lnk.state_out !== 2'd0) begin n_fail++; $display("FAIL en_state: got %0d want 0", lnk.state_out); end
        n_chk++; if ({lnk.valid_out, lnk.active_out, lnk.bitslip, lnk.sync_lost} !== 4'b0000) begin n_fail++; $display("FAIL en_flags: got %b want 0000", {lnk.valid_out, lnk.active_out, lnk.bitslip, lnk.sync_lost}); end
        n_chk++; if (lnk.data_out !== 8'h22) begin n_fail++; $display("FAIL en_data_hold: got %h want 22", lnk.data_out); end
    endtask

    task automatic test_slip();
        for (int b = 0; b < 2; b++) begin
            int pulses = 0;
            for (int i = 0; i < 16; i++) begin
                send(8'h5E);
                pulses += int'(lnk.bitslip);
                if (i == 14) begin
                    n_chk++; if (lnk.state_out !== 2'd0) begin n_fail++; $display("FAIL slip_pre_state[%0d]: got %0d want 0", b, lnk.state_out); end
                end
            end
            n_chk++; if ({pulses[1:0], lnk.bitslip} !== 3'b011) begin n_fail++; $display("FAIL slip_pulse[%0d]: got count=%0d now=%b want count=1 now=1", b, pulses, lnk.bitslip); end
            n_chk++; if (lnk.state_out !== 2'd1) begin n_fail++; $display("FAIL slip_state1[%0d]: got %0d want 1", b, lnk.state_out); end
            send(8'h5E);
            n_chk++; if ({lnk.state_out, lnk.bitslip} !== {2'd1, 1'b0}) begin n_fail++; $display("FAIL slip_state2[%0d]: got st=%0d bs=%b want st=1 bs=0", b, lnk.state_out, lnk.bitslip); end
            send(8'h5E);
            n_chk++; if (lnk.state_out !== 2'd0) begin n_fail++; $display("FAIL slip_return[%0d]: got %0d want 0", b, lnk.state_out); end
        end
    endtask

    task automatic test_lock_abort();
        int slips = 0;
        for (int i = 0; i < 3; i++) begin
            send(8'hBC);
            slips += int'(lnk.bitslip);
        end
        n_chk++; if (lnk.state_out !== 2'd2) begin n_fail++; $display("FAIL abort_locking: got %0d want 2", lnk.state_out); end
        send(8'h33);
        slips += int'(lnk.bitslip);
        n_chk++; if (lnk.state_out !== 2'd0) begin n_fail++; $display("FAIL abort_search: got %0d want 0", lnk.state_out); end
        for (int i = 0; i < 3; i++) begin
            send(8'hBC);
            slips += int'(lnk.bitslip);
        end
        n_chk++; if (lnk.active_out !== 1'b0) begin n_fail++; $display("FAIL abort_early_active: got %b want 0", lnk.active_out); end
        send(8'hBC);
        n_chk++; if ({lnk.active_out, lnk.state_out} !== {1'b1, 2'd3}) begin n_fail++; $display("FAIL abort_relock: got act=%b st=%0d want act=1 st=3", lnk.active_out, lnk.state_out); end
        n_chk++; if (slips !== 0) begin n_fail++; $display("FAIL abort_no_slip: got %0d pulses want 0", slips); end
    endtask

    task automatic test_gap();
        int fwd = 0;
        int lost = 0;
        for (int i = 0; i < 63; i++) begin
            send(8'hA5);
            if (lnk.valid_out && lnk.data_out == 8'hA5) fwd++;
            lost += int'(lnk.sync_lost);
        end
        n_chk++; if (fwd !== 63) begin n_fail++; $display("FAIL gap_forwarded: got %0d want 63", fwd); end
        n_chk++; if ({lnk.active_out, lost[0]} !== 2'b10) begin n_fail++; $display("FAIL gap_pre_loss: got act=%b lost=%0d want act=1 lost=0", lnk.active_out, lost); end
        send(8'hA5);
        n_chk++; if ({lnk.sync_lost, lnk.active_out, lnk.valid_out, lnk.state_out} !== {3'b100, 2'd0}) begin n_fail++; $display("FAIL gap_loss: got sl=%b act=%b v=%b st=%0d want sl=1 act=0 v=0 st=0", lnk.sync_lost, lnk.active_out, lnk.valid_out, lnk.state_out); end
        for (int i = 0; i < 4; i++) send(8'hBC);
        n_chk++; if ({lnk.sync_lost, lnk.active_out} !== 2'b01) begin n_fail++; $display("FAIL gap_relock: got sl=%b act=%b want sl=0 act=1", lnk.sync_lost, lnk.active_out); end
        lost = 0;
        for (int i = 0; i < 62; i++) begin
            send(8'hA5);
            lost += int'(lnk.sync_lost);
        end
        send(8'hBC);
        n_chk++; if ({lnk.valid_out, lnk.active_out} !== 2'b01) begin n_fail++; $display("FAIL gap_comma63: got v=%b act=%b want v=0 act=1", lnk.valid_out, lnk.active_out); end
        for (int i = 0; i < 63; i++) begin
            send(8'hA5);
            lost += int'(lnk.sync_lost);
        end
        n_chk++; if ({lost[0], lnk.active_out, lnk.valid_out, lnk.state_out} !== {3'b011, 2'd3}) begin n_fail++; $display("FAIL gap_reset_by_comma: got lost=%0d act=%b v=%b st=%0d want lost=0 act=1 v=1 st=3", lost, lnk.active_out, lnk.valid_out, lnk.state_out); end
    endtask

    task automatic test_async_reset();
        @(negedge clk_f);
        lnk.link_en = 1'b0;
        lnk.word_in = 8'hA5;
        @(posedge clk_f);
        #1;
        lnk.link_en = 1'b1;
        n_chk++; if ({lnk.state_out, lnk.active_out} !== {2'd0, 1'b0}) begin n_fail++; $display("FAIL ar_en_drop: got st=%0d act=%b want st=0 act=0", lnk.state_out, lnk.active_out); end
        send(8'hBC);
        send(8'hBC);
        n_chk++; if ({lnk.state_out, lnk.data_out} !== {2'd2, 8'hA5}) begin n_fail++; $display("FAIL ar_locking: got st=%0d d=%h want st=2 d=a5", lnk.state_out, lnk.data_out); end
        #3;
        reset_L = 1'b0;
        #1;
        n_chk++; if ({lnk.state_out, lnk.data_out} !== {2'd0, 8'h00}) begin n_fail++; $display("FAIL ar_state_data: got st=%0d d=%h want st=0 d=00", lnk.state_out, lnk.data_out); end
        n_chk++; if ({lnk.valid_out, lnk.active_out, lnk.bitslip, lnk.sync_lost} !== 4'b0000) begin n_fail++; $display("FAIL ar_flags: got %b want 0000", {lnk.valid_out, lnk.active_out, lnk.bitslip, lnk.sync_lost}); end
        @(negedge clk_f);
        reset_L = 1'b1;
    endtask

`ifdef LINK_SYNC_STATS_EN
    task automatic one_slip();
        for (int i = 0; i < 18; i++) send(8'h5E);
    endtask

    task automatic test_stats();
        n_chk++; if ({lnk.slip_cnt, lnk.loss_cnt} !== 16'h0000) begin n_fail++; $display("FAIL st_reset: got slip=%0d loss=%0d want 0 0", lnk.slip_cnt, lnk.loss_cnt); end
        for (int s = 0; s < 3; s++) one_slip();
        for (int i = 0; i < 4; i++) send(8'hBC);
        for (int i = 0; i < 64; i++) send(8'hA5);
        n_chk++; if ({lnk.slip_cnt, lnk.loss_cnt} !== {8'd3, 8'd1}) begin n_fail++; $display("FAIL st_counts: got slip=%0d loss=%0d want 3 1", lnk.slip_cnt, lnk.loss_cnt); end
        for (int i = 0; i < 15; i++) send(8'h5E);
        @(negedge clk_f);
        lnk.word_in   = 8'h5E;
        lnk.stats_clr = 1'b1;
        @(posedge clk_f);
        #1;
        lnk.stats_clr = 1'b0;
        n_chk++; if ({lnk.bitslip, lnk.slip_cnt, lnk.loss_cnt} !== {1'b1, 8'd0, 8'd0}) begin n_fail++; $display("FAIL st_clr_wins: got bs=%b slip=%0d loss=%0d want 1 0 0", lnk.bitslip, lnk.slip_cnt, lnk.loss_cnt); end
        send(8'h5E);
        send(8'h5E);
        for (int s = 0; s < 300; s++) one_slip();
        n_chk++; if ({lnk.slip_cnt, lnk.loss_cnt} !== {8'd255, 8'd0}) begin n_fail++; $display("FAIL st_saturate: got slip=%0d loss=%0d want 255 0", lnk.slip_cnt, lnk.loss_cnt); end
    endtask
`endif

    initial begin
        reset_L     = 1'b0;
        lnk.link_en = 1'b1;
        lnk.word_in = 8'h00;
`ifdef LINK_SYNC_STATS_EN
        lnk.stats_clr = 1'b0;
`endif
        test_reset();
        test_lock();
        test_link_en();
        test_slip();
        test_lock_abort();
        test_gap();
        test_async_reset();
`ifdef LINK_SYNC_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
